glip_jtag_output_fsm: RTL and testbench
=======================================

Name: glip_jtag_output_fsm

Overview:
JTAG-side return path of the GLIP JTAG backend; it sits beside the input FSM on the same DR scan chain. Logic-side words are pushed into an internal buffer over a valid/ready interface. During each DR scan the block does three things in order:
- shifts out the number of buffered words;
- reads the host's read-request count from tdi;
- shifts out up to that many words on tdo, LSB first.
A word is removed from the buffer only after its last bit has been shifted, so an aborted scan loses no data.

Parameters:
WORD_WIDTH, 16, bits per word and per count field
BUF_DEPTH, 4, buffer depth in words; must be < 2^WORD_WIDTH

Ports:
clk  in  1  JTAG clock (TCK domain), rising edge
rst  in  1  reset, synchronous, active-low
tdi  in  1  serial data from host
shift  in  1  TAP Shift-DR
capture  in  1  TAP Capture-DR
update  in  1  TAP Update-DR
tdo  out  1  serial data to host
in_data  in  WORD_WIDTH  logic-side word
in_valid  in  1  in_data valid
in_ready  out  1  buffer can accept a word
sent_cnt  out  WORD_WIDTH  words committed (popped) in the current scan

Behaviour:
- Reset (rst==0 at a posedge):
  - state IDLE; buffer emptied (pointers and count 0).
  - shift_reg, bit_cnt, req, avail_snap, words_left, sent_cnt all 0.
  - tdo 0; in_ready forced 0 while rst==0.
  - Reset mid-scan discards all buffered words.
- Buffer:
  - in_ready = !full.
  - Push on in_valid && in_ready.
  - A push and a pop may occur in the same cycle; the count is unchanged.
  - When full, in_ready=0 even if a pop happens that cycle.
- tdo is combinational: shift_reg[0] in SEND_AVAIL/SEND_DATA, else 0.
  - The first bit is valid in the cycle after capture, before the first shift.
- update (any state) -> IDLE next cycle; no pop; sent_cnt held.
- capture (any state, update not asserted) -> SEND_AVAIL:
  - avail_snap = buffer count, excluding any push in the same cycle.
  - shift_reg = avail_snap; bit_cnt = 0; sent_cnt = 0.
- States; each advances only on cycles with shift==1 and holds otherwise:
  - IDLE: tdo 0; wait for capture.
  - SEND_AVAIL:
    - shift_reg >>= 1; bit_cnt++.
    - At bit_cnt==WORD_WIDTH-1: bit_cnt=0, shift_reg=0, go to READ_REQ.
  - READ_REQ:
    - req[bit_cnt] = tdi; bit_cnt++.
    - At the last bit: n = min({tdi, req[WORD_WIDTH-2:0]}, avail_snap), unsigned compare.
    - If n==0 -> DONE.
    - Otherwise words_left=n, shift_reg=buffer head, bit_cnt=0 -> SEND_DATA.
  - SEND_DATA:
    - shift_reg >>= 1; bit_cnt++.
    - At the last bit: pop head; sent_cnt++; words_left--; bit_cnt=0.
    - If words_left was 1 -> DONE; otherwise shift_reg = the entry following the popped one -> SEND_DATA.
  - DONE: tdo 0; ignore shift; wait for update/capture.
- Words pushed after the capture snapshot are never sent in that scan, so the buffer can never underrun.
- Latency: a word pushed at cycle t is reported by any capture at cycle ≥ t+1.
- Counters are WORD_WIDTH wide and cannot wrap, because n ≤ BUF_DEPTH.

Test Plan:
1. Reset: hold rst=0 for 2 cycles with in_valid=1 -> tdo=0, in_ready=0, no push; after release in_ready=1 and a capture reports avail 0x0000.
2. Push 0xA5A5 then 0x1234; capture; 16 shifts -> tdo LSB-first = 0x0002. Then shift tdi req=0x0005 over 16 bits, then 32 shifts -> tdo = 0xA5A5 then 0x1234; sent_cnt=2; further shifts give tdo=0 (DONE); buffer empty.
3. Push 3 words; scan with req=0x0001 -> only word 0 sent, sent_cnt=1; next scan reports avail 0x0002 and starts with word 1.
4. Push 4 words -> in_ready=0; 5th in_valid ignored. During SEND_DATA the last-bit pop with in_valid=1 in the same cycle does not push; in_ready=1 the next cycle.
5. Abort: assert update after 8 bits of the first data word -> IDLE, no pop. Next scan reports the same avail and the same first word.
6. Push in the same cycle as capture (buffer empty) -> avail reported 0x0000 and req=0xFFFF sends nothing; next scan reports 0x0001.

Source files
------------

// File: rtl/glip_jtag_output_fsm.sv
// GLIP JTAG backend, return path: buffers logic-side words and returns them
// to the host over the DR scan chain. Each scan sends the buffered word count,
// reads the host's request count, then sends up to that many words LSB first.
module glip_jtag_output_fsm #(
  parameter int WORD_WIDTH = 16,
  parameter int BUF_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tdi,
  input  logic                  shift,
  input  logic                  capture,
  input  logic                  update,
  output logic                  tdo,
  input  logic [WORD_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WORD_WIDTH-1:0] sent_cnt
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int BW = $clog2(WORD_WIDTH);

  typedef enum logic [2:0] {IDLE, SEND_AVAIL, READ_REQ, SEND_DATA, DONE} state_t;

  state_t                state, state_nxt;
  logic [WORD_WIDTH-1:0] mem [BUF_DEPTH];
  logic [PW-1:0]         rd_ptr, wr_ptr;
  logic [CW-1:0]         count;
  logic                  full, push, pop, advance, last_bit;
  logic [WORD_WIDTH-1:0] shift_reg, bit_cnt, avail_snap, words_left;
  logic [WORD_WIDTH-2:0] req;
  logic [WORD_WIDTH-1:0] req_full, n_words;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full     = (count == CW'(BUF_DEPTH));
  assign in_ready = rst & ~full;
  assign push     = in_valid & in_ready;
  assign advance  = shift & ~update & ~capture;
  assign last_bit = (bit_cnt == WORD_WIDTH'(WORD_WIDTH - 1));
  // A word leaves the buffer only once its final bit has gone out.
  assign pop      = advance && (state == SEND_DATA) && last_bit;
  // The MSB of the request arrives on tdi in the same cycle as the decision.
  assign req_full = {tdi, req};
  assign n_words  = (req_full < avail_snap) ? req_full : avail_snap;

  // Buffer pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Buffer storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state: update beats capture beats shift; no shift means hold
  always_comb begin
    state_nxt = state;
    if (update)       state_nxt = IDLE;
    else if (capture) state_nxt = SEND_AVAIL;
    else if (shift) begin
      case (state)
        SEND_AVAIL: if (last_bit) state_nxt = READ_REQ;
        READ_REQ:   if (last_bit) state_nxt = (n_words == '0) ? DONE : SEND_DATA;
        SEND_DATA:  if (last_bit && words_left == WORD_WIDTH'(1)) state_nxt = DONE;
        default:    state_nxt = state;
      endcase
    end
  end

  // Scan datapath: shifter, bit counter, request capture, word accounting
  always_ff @(posedge clk) begin
    if (!rst) begin
      shift_reg  <= '0;
      bit_cnt    <= '0;
      req        <= '0;
      avail_snap <= '0;
      words_left <= '0;
      sent_cnt   <= '0;
    end else if (update) begin
      // Abort/finish: keep everything, including sent_cnt for the logic side.
    end else if (capture) begin
      // Snapshot excludes a same-cycle push, so the scan never underruns.
      avail_snap <= WORD_WIDTH'(count);
      shift_reg  <= WORD_WIDTH'(count);
      bit_cnt    <= '0;
      sent_cnt   <= '0;
    end else if (shift) begin
      case (state)
        SEND_AVAIL: begin
          if (last_bit) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
          end else begin
            bit_cnt   <= bit_cnt + 1'b1;
            shift_reg <= shift_reg >> 1;
          end
        end
        READ_REQ: begin
          if (last_bit) begin
            bit_cnt <= '0;
            if (n_words != '0) begin
              words_left <= n_words;
              shift_reg  <= mem[rd_ptr];
            end
          end else begin
            req[bit_cnt[BW-1:0]] <= tdi;
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        SEND_DATA: begin
          if (last_bit) begin
            bit_cnt    <= '0;
            sent_cnt   <= sent_cnt + 1'b1;
            words_left <= words_left - 1'b1;
            // Next entry was already present at the snapshot, so it is valid.
            if (words_left != WORD_WIDTH'(1)) shift_reg <= mem[ptr_inc(rd_ptr)];
            else                              shift_reg <= shift_reg >> 1;
          end else begin
            bit_cnt   <= bit_cnt + 1'b1;
            shift_reg <= shift_reg >> 1;
          end
        end
        default: ;
      endcase
    end
  end

  // Serial output: only the two send states drive data
  always_comb begin
    tdo = 1'b0;
    if (state == SEND_AVAIL || state == SEND_DATA) tdo = shift_reg[0];
  end

endmodule

// File: tb/tb_glip_jtag_output_fsm.sv
// Bench for glip_jtag_output_fsm: a queue stands in for the buffer and each
// scan is predicted from the count / request / min rule.
module tb_glip_jtag_output_fsm;
  localparam int W = 16;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         tdi = 1'b0, shift = 1'b0, capture = 1'b0, update = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         tdo, in_ready;
  logic [W-1:0] sent_cnt;

  int vectors = 0;
  int errors  = 0;
  logic [W-1:0] q[$];

  glip_jtag_output_fsm #(.WORD_WIDTH(W), .BUF_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .tdi(tdi), .shift(shift), .capture(capture),
    .update(update), .tdo(tdo), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .sent_cnt(sent_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [W-1:0] d);
    bit exp_rdy;
    exp_rdy  = (q.size() < D);
    in_valid = 1'b1;
    in_data  = d;
    vectors++;
    if (in_ready !== exp_rdy) begin
      errors++;
      $display("FAIL push_ready: got %b want %b", in_ready, exp_rdy);
    end
    tick();
    if (exp_rdy) q.push_back(d);
    in_valid = 1'b0;
  endtask

  // Full scan: capture, avail, request, data words, DONE, update.
  task automatic do_scan(input logic [W-1:0] req, input int abort_bits,
                         input bit push_on_pop, input bit push_at_cap);
    logic [W-1:0] got, exp_avail, exp_word, extra_d;
    int n, sent, bits;
    bit aborted, acc;
    exp_avail = W'(q.size());
    extra_d   = W'($urandom);
    capture   = 1'b1;
    shift     = 1'b0;
    if (push_at_cap) begin in_valid = 1'b1; in_data = extra_d; end
    tick();
    capture = 1'b0;
    if (push_at_cap) begin
      in_valid = 1'b0;
      if (q.size() < D) q.push_back(extra_d);
    end
    vectors++;
    if (sent_cnt !== '0) begin
      errors++;
      $display("FAIL sent_cleared: got %h want 0000", sent_cnt);
    end
    shift = 1'b1;
    got = '0;
    for (int i = 0; i < W; i++) begin got[i] = tdo; tick(); end
    vectors++;
    if (got !== exp_avail) begin
      errors++;
      $display("FAIL avail: got %h want %h", got, exp_avail);
    end
    got = '0;
    for (int i = 0; i < W; i++) begin got[i] = tdo; tdi = req[i]; tick(); end
    tdi = 1'b0;
    vectors++;
    if (got !== '0) begin
      errors++;
      $display("FAIL req_phase_tdo: got %h want 0000", got);
    end
    n = (req < exp_avail) ? int'(req) : int'(exp_avail);
    sent = 0; bits = 0; aborted = 1'b0;
    for (int w = 0; w < n; w++) begin
      exp_word = q[0];
      got = '0;
      for (int i = 0; i < W; i++) begin
        if (bits == abort_bits) begin aborted = 1'b1; break; end
        got[i] = tdo;
        if (push_on_pop && i == W - 1) begin in_valid = 1'b1; in_data = extra_d; end
        tick();
        bits++;
      end
      if (aborted) break;
      acc = push_on_pop && (q.size() < D);
      in_valid = 1'b0;
      void'(q.pop_front());
      if (acc) q.push_back(extra_d);
      sent++;
      vectors++;
      if (got !== exp_word) begin
        errors++;
        $display("FAIL data_word%0d: got %h want %h", w, got, exp_word);
      end
      vectors++;
      if (sent_cnt !== W'(sent)) begin
        errors++;
        $display("FAIL sent_cnt: got %0d want %0d", sent_cnt, sent);
      end
      vectors++;
      if (in_ready !== (q.size() < D)) begin
        errors++;
        $display("FAIL ready_after_pop: got %b want %b", in_ready, q.size() < D);
      end
    end
    if (!aborted) begin
      got = '0;
      for (int i = 0; i < 4; i++) begin got[i] = tdo; tick(); end
      vectors++;
      if (got !== '0) begin
        errors++;
        $display("FAIL done_tdo: got %h want 0000", got);
      end
    end
    shift  = 1'b0;
    update = 1'b1;
    tick();
    update = 1'b0;
    vectors++;
    if (sent_cnt !== W'(sent) || tdo !== 1'b0) begin
      errors++;
      $display("FAIL after_update: sent_cnt %0d tdo %b want %0d 0", sent_cnt, tdo, sent);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b1; in_data = 16'hBEEF;
    tick(); tick();
    vectors++;
    if (tdo !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: tdo %b in_ready %b want 0 0", tdo, in_ready);
    end
    rst = 1'b1; in_valid = 1'b0;
    tick();
    vectors++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got %b want 1", in_ready);
    end
    do_scan(16'h0000, -1, 1'b0, 1'b0);
  endtask

  task automatic test_basic();
    push_word(16'hA5A5);
    push_word(16'h1234);
    do_scan(16'h0005, -1, 1'b0, 1'b0);
  endtask

  task automatic test_partial();
    push_word(16'h1111); push_word(16'h2222); push_word(16'h3333);
    do_scan(16'h0001, -1, 1'b0, 1'b0);
    do_scan(16'h0002, -1, 1'b0, 1'b0);
  endtask

  task automatic test_full();
    for (int i = 0; i < 5; i++) push_word(W'($urandom));
    do_scan(16'h0001, -1, 1'b1, 1'b0);
    do_scan(16'hFFFF, -1, 1'b0, 1'b0);
  endtask

  task automatic test_abort();
    push_word(16'hC0DE); push_word(16'hF00D);
    do_scan(16'h0002, 8, 1'b0, 1'b0);
    do_scan(16'h0002, -1, 1'b0, 1'b0);
  endtask

  task automatic test_push_at_capture();
    do_scan(16'hFFFF, -1, 1'b0, 1'b1);
    do_scan(16'hFFFF, -1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_midscan();
    push_word(16'h5555); push_word(16'h6666);
    capture = 1'b1; tick(); capture = 1'b0;
    shift = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    shift = 1'b0; rst = 1'b0;
    tick();
    rst = 1'b1;
    q.delete();
    tick();
    do_scan(16'hFFFF, -1, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [W-1:0] req;
    int ab;
    for (int it = 0; it < 25; it++) begin
      for (int k = $urandom_range(0, 5); k > 0; k--) push_word(W'($urandom));
      req = ($urandom_range(0, 3) == 0) ? 16'hFFFF : W'($urandom_range(0, 5));
      ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : -1;
      do_scan(req, ab, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial();
    test_full();
    test_abort();
    test_push_at_capture();
    test_reset_midscan();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
